// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
// Latency: none (declarations only).
// Backpressure: n/a.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] STRB_B = 4'b0001;
    localparam logic [3:0] STRB_H = 4'b0011;
    localparam logic [3:0] STRB_W = 4'b1111;

    // True when the byte offset is not a multiple of the access size.
    // Any funct3 that is not a byte/halfword encoding is a word access.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = off[0];
            default:     mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/grant/response port bundle.
// Latency: none (wires only).
// Backpressure: requester holds dm_req and its fields until dm_gnt.
interface mem_stage_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
);
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_wstrb;
    logic [XLEN-1:0]   dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [XLEN-1:0]   dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Store lane replication/strobes and load lane extraction with sign/zero extension.
// Latency: purely combinational.
// Backpressure: none.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] rs2_i,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store: replicate the source across every lane it could land in and enable only the addressed lanes.
    always_comb begin
        st_wdata_o = rs2_i;
        st_wstrb_o = STRB_W;
        case (st_funct3_i)
            F3_B: begin
                st_wdata_o = {4{rs2_i[7:0]}};
                st_wstrb_o = STRB_B << st_off_i;
            end
            F3_H: begin
                st_wdata_o = {2{rs2_i[15:0]}};
                st_wstrb_o = STRB_H << {st_off_i[1], 1'b0};
            end
            default: begin
                st_wdata_o = rs2_i;
                st_wstrb_o = STRB_W;
            end
        endcase
    end

    // Load: pick the addressed lane, then extend it according to the signedness of the op.
    always_comb begin
        ld_byte = rdata_i[7:0];
        case (ld_off_i)
            2'd0: ld_byte = rdata_i[7:0];
            2'd1: ld_byte = rdata_i[15:8];
            2'd2: ld_byte = rdata_i[23:16];
            2'd3: ld_byte = rdata_i[31:24];
            default: ld_byte = rdata_i[7:0];
        endcase
        ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data_o = {24'd0, ld_byte};
            F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data_o = {16'd0, ld_half};
            default: ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: issues one data-memory access per load/store and returns extended load data.
// Latency: store 3 cycles (accept, REQ, DONE), load 4 cycles minimum; each gnt/rvalid wait adds one.
// Backpressure: lsu_stall freezes the pipeline from accept until DONE; optional trap via LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        mem_funct3,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              flush,
    mem_stage_lsu_if.master   dm,
    output logic              lsu_stall,
    output logic              ld_valid,
    output logic [XLEN-1:0]   ld_data,
    output logic              misalign_exc
);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic              we_q;
    logic [XLEN-1:0]   wdata_q;
    logic [3:0]        wstrb_q;
    logic [XLEN-1:0]   ld_data_q;

    logic              mem_op;
    logic              accept;
    logic              trap;
    logic              stall;
    logic [31:0]       st_wdata;
    logic [3:0]        st_wstrb;
    logic [31:0]       ld_ext;

    // rst gates the request so that nothing combinational leaks out while reset is held
    assign mem_op = rst & mem_valid & (mem_rd | mem_wr) & ~flush;

    lsu_align u_align (
        .st_funct3_i (mem_funct3),
        .st_off_i    (alu_out[1:0]),
        .rs2_i       (rs2_data),
        .st_wdata_o  (st_wdata),
        .st_wstrb_o  (st_wstrb),
        .ld_funct3_i (f3_q),
        .ld_off_i    (addr_q[1:0]),
        .rdata_i     (dm.dm_rdata),
        .ld_data_o   (ld_ext)
    );

    // Next-state and stall: accept in IDLE, hold through the bus handshake, release in DONE.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        trap    = 1'b0;
        stall   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(mem_funct3, alu_out[1:0])) begin
                        trap = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        stall   = 1'b1;
                        state_d = ST_REQ;
                    end
`else
                    accept  = 1'b1;
                    stall   = 1'b1;
                    state_d = ST_REQ;
`endif
                end
            end
            ST_REQ: begin
                stall = 1'b1;
                if (dm.dm_gnt) begin
                    state_d = we_q ? ST_DONE : ST_RESP;
                end
            end
            ST_RESP: begin
                stall = 1'b1;
                if (dm.dm_rvalid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request fields and load result; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            f3_q      <= F3_W;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            ld_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= alu_out[ADDR_W-1:0];
                f3_q    <= mem_funct3;
                we_q    <= mem_wr;
                wdata_q <= st_wdata;
                wstrb_q <= mem_wr ? st_wstrb : 4'b0000;
            end
            if (state_q == ST_RESP && dm.dm_rvalid) begin
                ld_data_q <= ld_ext;
            end
        end
    end

    assign dm.dm_req    = (state_q == ST_REQ);
    assign dm.dm_we     = we_q;
    assign dm.dm_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign dm.dm_wstrb  = wstrb_q;
    assign dm.dm_wdata  = wdata_q;

    assign lsu_stall    = stall;
    assign ld_valid     = (state_q == ST_DONE) & ~we_q;
    assign ld_data      = ld_data_q;
    assign misalign_exc = trap;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases plus randomized loads/stores against a behavioural model.
// Latency: n/a.
// Backpressure: the bench plays the memory side with programmable gnt/rvalid delays.
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        mem_valid, mem_rd, mem_wr, flush;
    logic [2:0]  mem_funct3;
    logic [31:0] alu_out, rs2_data;
    logic        lsu_stall, ld_valid, misalign_exc;
    logic [31:0] ld_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] last_ld;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb;

    mem_stage_lsu_if #(.ADDR_W(32), .XLEN(32)) dm_if ();

    mem_stage_lsu #(.ADDR_W(32), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_valid    (mem_valid),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_funct3   (mem_funct3),
        .alu_out      (alu_out),
        .rs2_data     (rs2_data),
        .flush        (flush),
        .dm           (dm_if),
        .lsu_stall    (lsu_stall),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .misalign_exc (misalign_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int lane_base(input logic [2:0] f3, input logic [31:0] a);
        int s   = acc_size(f3);
        int off = int'(a % 32'd4);
        return off - (off % s);
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int s = acc_size(f3);
        int v = ((1 << s) - 1) << lane_base(f3, a);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        int s = acc_size(f3);
        if (s == 1) return (d % 32'd256) * 32'h01010101;
        if (s == 2) return (d % 32'd65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int          s = acc_size(f3);
        logic [31:0] v;
        logic [31:0] span;
        if (s == 4) return rd;
        span = 32'd1 << (8 * s);
        v = (rd >> (8 * lane_base(f3, a))) % span;
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= (span >> 1)) v = v - span;
        return v;
    endfunction

    // One complete access: accept in IDLE, gdly cycles without grant, then rwait cycles without rvalid.
    task automatic run_op(input bit is_ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input int gdly, input int rwait,
                          input logic [31:0] rdata, input string tag);
        int          stalls = 0;
        int          exp_stalls;
        logic [31:0] exp_ld;
        exp_ld     = m_load(f3, addr, rdata);
        exp_stalls = 2 + gdly + (is_ld ? 1 + rwait : 0);

        @(negedge clk);
        mem_valid = 1'b1; mem_rd = is_ld; mem_wr = !is_ld;
        mem_funct3 = f3; alu_out = addr; rs2_data = rs2;
        #1;
        if (lsu_stall) stalls++;
        chk1({tag, "/idle_no_req"}, dm_if.dm_req, 1'b0);
        chk1({tag, "/idle_no_exc"}, misalign_exc, 1'b0);

        for (int i = 0; i <= gdly; i++) begin
            @(negedge clk);
            if (i == gdly) dm_if.dm_gnt = 1'b1;
            #1;
            if (lsu_stall) stalls++;
            chk1({tag, "/req"}, dm_if.dm_req, 1'b1);
            chk1({tag, "/we"}, dm_if.dm_we, !is_ld);
            chk32({tag, "/addr"}, dm_if.dm_addr, addr & 32'hFFFF_FFFC);
            if (!is_ld) begin
                chk32({tag, "/wstrb"}, {28'd0, dm_if.dm_wstrb}, {28'd0, m_strb(f3, addr)});
                chk32({tag, "/wdata"}, dm_if.dm_wdata, m_wdata(f3, rs2));
            end
            cap_addr = dm_if.dm_addr; cap_strb = dm_if.dm_wstrb; cap_wdata = dm_if.dm_wdata;
        end
        @(negedge clk);
        dm_if.dm_gnt = 1'b0;

        if (is_ld) begin
            for (int i = 0; i <= rwait; i++) begin
                if (i > 0) @(negedge clk);
                if (i == rwait) begin
                    dm_if.dm_rvalid = 1'b1;
                    dm_if.dm_rdata  = rdata;
                end
                #1;
                if (lsu_stall) stalls++;
                chk1({tag, "/resp_no_req"}, dm_if.dm_req, 1'b0);
                chk1({tag, "/resp_no_vld"}, ld_valid, 1'b0);
            end
            @(negedge clk);
            dm_if.dm_rvalid = 1'b0;
            dm_if.dm_rdata  = $urandom;
        end

        mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        #1;
        chk1({tag, "/done_stall"}, lsu_stall, 1'b0);
        chk1({tag, "/done_vld"}, ld_valid, is_ld);
        if (is_ld) last_ld = exp_ld;
        chk32({tag, "/ld_data"}, ld_data, last_ld);
        chk32({tag, "/stall_cycles"}, stalls, exp_stalls);

        @(negedge clk);
        #1;
        chk1({tag, "/idle_vld_low"}, ld_valid, 1'b0);
        chk32({tag, "/ld_hold"}, ld_data, last_ld);
    endtask

    logic [2:0] ld_f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_f3s [3] = '{3'b000, 3'b001, 3'b010};

    initial begin
        rst = 1'b0; mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; flush = 1'b0;
        mem_funct3 = 3'b000; alu_out = '0; rs2_data = '0;
        dm_if.dm_gnt = 1'b0; dm_if.dm_rvalid = 1'b0; dm_if.dm_rdata = '0;
        last_ld = '0;

        // Reset state
        #12;
        chk1("rst/req", dm_if.dm_req, 1'b0);
        chk1("rst/stall", lsu_stall, 1'b0);
        chk1("rst/ld_valid", ld_valid, 1'b0);
        chk32("rst/ld_data", ld_data, 32'd0);
        chk32("rst/addr", dm_if.dm_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // SB at 0x1003, grant in the first REQ cycle
        run_op(1'b0, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 32'd0, "sb");
        chk32("sb/addr_const", cap_addr, 32'h0000_1000);
        chk32("sb/strb_const", {28'd0, cap_strb}, 32'h8);
        chk32("sb/wdata_const", cap_wdata, 32'hA5A5_A5A5);

        // LB then LBU from 0x2001
        run_op(1'b1, 3'b000, 32'h0000_2001, 32'd0, 0, 0, 32'h0000_F000, "lb");
        chk32("lb/const", ld_data, 32'hFFFF_FFF0);
        run_op(1'b1, 3'b100, 32'h0000_2001, 32'd0, 0, 0, 32'h0000_F000, "lbu");
        chk32("lbu/const", ld_data, 32'h0000_00F0);

        // LW with grant delayed 3 cycles, rvalid 2 cycles after grant
        run_op(1'b1, 3'b010, 32'h0000_0100, 32'd0, 3, 1, 32'h1234_5678, "lw_slow");
        chk32("lw_slow/const", ld_data, 32'h1234_5678);

        // Store leaves the last load result untouched
        run_op(1'b0, 3'b001, 32'h0000_0202, 32'hCAFE_BEEF, 1, 0, 32'd0, "sh");

        // Reset while in RESP
        @(negedge clk);
        mem_valid = 1'b1; mem_rd = 1'b1; mem_funct3 = 3'b010; alu_out = 32'h40;
        @(negedge clk);
        dm_if.dm_gnt = 1'b1;
        @(negedge clk);
        dm_if.dm_gnt = 1'b0;
        #1;
        chk1("rstresp/stall_pre", lsu_stall, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("rstresp/req", dm_if.dm_req, 1'b0);
        chk1("rstresp/we", dm_if.dm_we, 1'b0);
        chk32("rstresp/addr", dm_if.dm_addr, 32'd0);
        chk32("rstresp/wstrb", {28'd0, dm_if.dm_wstrb}, 32'd0);
        chk32("rstresp/wdata", dm_if.dm_wdata, 32'd0);
        chk1("rstresp/stall", lsu_stall, 1'b0);
        chk1("rstresp/ld_valid", ld_valid, 1'b0);
        chk32("rstresp/ld_data", ld_data, 32'd0);
        chk1("rstresp/exc", misalign_exc, 1'b0);
        mem_valid = 1'b0; mem_rd = 1'b0;
        last_ld = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dm_if.dm_rvalid = 1'b1; dm_if.dm_rdata = 32'hDEAD_BEEF;
        #1;
        chk1("late_rv/ld_valid0", ld_valid, 1'b0);
        chk1("late_rv/stall", lsu_stall, 1'b0);
        @(negedge clk);
        dm_if.dm_rvalid = 1'b0;
        #1;
        chk1("late_rv/ld_valid1", ld_valid, 1'b0);
        chk32("late_rv/ld_data", ld_data, 32'd0);
        run_op(1'b1, 3'b001, 32'h0000_0046, 32'd0, 0, 0, 32'h8001_7FFF, "fresh_lh");
        chk32("fresh_lh/const", ld_data, 32'hFFFF_8001);

        // Misaligned word load at 0x3002
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        mem_valid = 1'b1; mem_rd = 1'b1; mem_funct3 = 3'b010; alu_out = 32'h0000_3002;
        #1;
        chk1("mis/exc", misalign_exc, 1'b1);
        chk1("mis/stall", lsu_stall, 1'b0);
        chk1("mis/req0", dm_if.dm_req, 1'b0);
        @(negedge clk);
        mem_valid = 1'b0; mem_rd = 1'b0;
        #1;
        chk1("mis/exc_clr", misalign_exc, 1'b0);
        chk1("mis/req1", dm_if.dm_req, 1'b0);
`else
        run_op(1'b1, 3'b010, 32'h0000_3002, 32'd0, 0, 0, 32'h0BAD_F00D, "mis_lw");
        chk32("mis_lw/addr_const", cap_addr, 32'h0000_3000);
        chk32("mis_lw/data_const", ld_data, 32'h0BAD_F00D);
`endif

        // Flush with a valid store in IDLE
        @(negedge clk);
        mem_valid = 1'b1; mem_wr = 1'b1; flush = 1'b1; mem_funct3 = 3'b010; alu_out = 32'h500;
        #1;
        chk1("flush/stall", lsu_stall, 1'b0);
        chk1("flush/req0", dm_if.dm_req, 1'b0);
        @(negedge clk);
        #1;
        chk1("flush/req1", dm_if.dm_req, 1'b0);
        mem_valid = 1'b0; mem_wr = 1'b0; flush = 1'b0;

        // Randomized loads and stores
        for (int k = 0; k < 40; k++) begin
            bit          ld;
            logic [2:0]  f3;
            logic [31:0] a;
            ld = 1'($urandom_range(0, 1));
            f3 = ld ? ld_f3s[$urandom_range(0, 4)] : st_f3s[$urandom_range(0, 2)];
            a  = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
            a = a - (a % 32'(acc_size(f3)));
`endif
            run_op(ld, f3, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                   $urandom, ld ? "rnd_ld" : "rnd_st");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the 5-stage core. Consumes the EX/MEM pipeline register's ALU result (effective address) and rs2 store data, plus the memory-op control. Runs a request/grant/response handshake with the data-memory port, aligns store data and byte strobes, and extracts and sign-extends load data for writeback. Drives the pipeline stall that freezes the EX/MEM register and upstream stages while an access is outstanding.

## Interface
- ADDR_W, 32: data-memory address width.
- XLEN, 32: data width.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_valid  in  1  EX/MEM holds a valid instruction.
- mem_rd  in  1  instruction is a load.
- mem_wr  in  1  instruction is a store. mem_rd and mem_wr are never both 1.
- mem_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_out  in  XLEN  effective byte address.
- rs2_data  in  XLEN  store source.
- flush  in  1  kill the current instruction; honoured only in IDLE.
- dm_req  out  1  bus request.
- dm_we  out  1  1 = write.
- dm_addr  out  ADDR_W  word-aligned address ({alu_out[31:2],2'b00}).
- dm_wstrb  out  4  byte enables.
- dm_wdata  out  XLEN  lane-replicated store data.
- dm_gnt  in  1  request accepted this cycle.
- dm_rvalid  in  1  read data valid.
- dm_rdata  in  XLEN  read word.
- lsu_stall  out  1  freezes EX/MEM and upstream registers.
- ld_valid  out  1  one-cycle pulse; ld_data valid.
- ld_data  out  XLEN  extended load result.
- misalign_exc  out  1  misaligned access (only with the macro).

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE
  - mem_valid & (mem_rd|mem_wr) & !flush: latch address, funct3, rd/wr and aligned wdata/wstrb, then go to REQ. lsu_stall=1 combinationally in this cycle.
  - Otherwise stay in IDLE with lsu_stall=0.
- REQ: dm_req=1. dm_we, dm_addr, dm_wstrb and dm_wdata stay stable from the latched copies until dm_gnt. On dm_gnt a store goes to DONE and a load goes to RESP.
- RESP: wait for dm_rvalid. When it arrives, extract the lane at addr[1:0], zero- or sign-extend it into ld_data, then go to DONE.
- DONE: lsu_stall=0. ld_valid=1 for a load only. Return to IDLE.
- In REQ and RESP, lsu_stall=1 and flush is ignored: a bus transaction always completes.
- Store alignment:
  - SB: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=rs2, wstrb=4'b1111.
- Load extraction:
  - B/BU take byte addr[1:0].
  - H/HU take halfword addr[1].
  - Sign-extend B/H; zero-extend BU/HU.
  - Undefined funct3 is treated as W.
- ld_data holds its value until the next load completes.

## Timing
- Reset (rst=0, any state): FSM goes to IDLE. dm_req, dm_we, dm_addr, dm_wstrb, dm_wdata, ld_valid, ld_data and misalign_exc are all 0. lsu_stall=0.
- A reset in REQ or RESP abandons the access. A dm_rvalid that arrives after reset is ignored.
- Store with dm_gnt in the first REQ cycle takes 3 cycles: IDLE (accept), REQ, DONE.
- Load with gnt and rvalid each one cycle later takes 4 cycles minimum. Every wait cycle adds one.
- dm_rvalid in the same cycle as dm_gnt is not legal; the bus returns data at least one cycle after grant.
- The next instruction is sampled in the first IDLE cycle after DONE. Back-to-back accesses have no bubble beyond DONE.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - An H/HU/SH access with addr[0]=1, or a W access with addr[1:0]≠0, raises misalign_exc for one cycle in IDLE.
  - No bus request is issued, lsu_stall stays 0, and the FSM stays in IDLE.
- LSU_MISALIGN_TRAP_EN undefined:
  - misalign_exc is tied to 0.
  - Misaligned accesses proceed with the low address bits ignored for the access size (H uses addr[1], W uses lane 0).

## Structure
- Shared package lsu_pkg:
  - FSM state enum.
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Strobe constants.
- Sub-module lsu_align (combinational): store data/strobe generation and load extract/extend. FSM, latches and handshake stay in mem_stage_lsu.

## Test plan
- SB: addr=0x1003, rs2=0x000000A5, gnt in first REQ cycle -> dm_addr=0x1000, wstrb=4'b1000, wdata=0xA5A5A5A5. lsu_stall high for exactly 2 cycles.
- LB then LBU: addr=0x2001, rdata=0x0000F000 -> ld_data 0xFFFFFFF0 then 0x000000F0, with one ld_valid pulse each.
- LW: gnt delayed 3 cycles, rvalid 2 cycles after gnt -> request fields stable throughout, lsu_stall high until DONE, ld_data=rdata.
- rst asserted in RESP -> all outputs 0 immediately. A late rvalid produces no ld_valid. A fresh load completes normally.
- With LSU_MISALIGN_TRAP_EN: LW at 0x3002 -> misalign_exc=1 for one cycle, dm_req never asserted. Without the macro -> access at 0x3000 completes.
- flush with a valid store in IDLE -> no dm_req, lsu_stall stays 0.
